mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 157 +++++++++++++++
 tb/tb_mc_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS-32 control unit: Moore FSM driving the datapath selects and strobes.
// Reset parks the machine in FETCH with all write strobes held low.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTEXE   = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEXE = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t curState;
    state_t nextState;
    logic       functLegal;
    logic [2:0] functAlu;

    // An illegal funct sends the R-type back to FETCH instead of executing.
    always_comb begin
        functLegal = 1'b1;
        functAlu   = 3'b010;
        case (funct)
            6'b100000: functAlu = 3'b010;
            6'b100010: functAlu = 3'b110;
            6'b100100: functAlu = 3'b000;
            6'b100101: functAlu = 3'b001;
            6'b101010: functAlu = 3'b111;
            6'b000000: functAlu = 3'b100;
            6'b000010: functAlu = 3'b101;
            default:   functLegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            curState <= FETCH;
        else
            curState <= nextState;
    end

    always_comb begin
        nextState = FETCH;
        case (curState)
            FETCH:  nextState = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = functLegal ? RTEXE : FETCH;
                    OP_BEQ:       nextState = BRANCH;
                    OP_ADDI:      nextState = ADDIEXE;
                    OP_J:         nextState = JUMP;
                    default:      nextState = FETCH;
                endcase
            end
            MEMADR:  nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nextState = MEMWB;
            RTEXE:   nextState = ALUWB;
            ADDIEXE: nextState = ADDIWB;
            default: nextState = FETCH;
        endcase
    end

    // Moore outputs; zero only reaches pcen in BRANCH so beq is the sole conditional PC write.
    always_comb begin
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        alucontrol = 3'b010;
        if (reset) begin
            alusrcb = 2'b01;
        end else begin
            case (curState)
                FETCH: begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    alusrcb = 2'b01;
                end
                DECODE: alusrcb = 2'b11;
                MEMADR, ADDIEXE: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: iord = 1'b1;
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                RTEXE: begin
                    alusrca    = 1'b1;
                    alucontrol = functAlu;
                end
                ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                ADDIWB: regwrite = 1'b1;
                BRANCH: begin
                    alusrca    = 1'b1;
                    alucontrol = 3'b110;
                    pcsrc      = 2'b01;
                    pcen       = zero;
                end
                JUMP: begin
                    pcsrc = 2'b10;
                    pcen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = curState;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed table, reset corner case and random
// instruction streams compared against an instruction-level reference model.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic [14:0] dutOut;

    int assertCount = 0;
    int failCount   = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    assign dutOut = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, pcsrc, pcen, alucontrol};

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cycles;
        logic [2:0] alu2;
        int         rw;
        int         mw;
        int         pe;
    } vec_t;

    function automatic logic modelLegal(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                          6'b101010, 6'b000000, 6'b000010};
    endfunction

    function automatic logic [2:0] modelAlu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            6'b000000: return 3'b100;
            6'b000010: return 3'b101;
            default:   return 3'b010;
        endcase
    endfunction

    // State visited at step k of one instruction; past the end the next FETCH (0) follows.
    function automatic int stateAt(input logic [5:0] op, input logic [5:0] fn, input int k);
        int path[5];
        int len;
        path = '{0, 1, 0, 0, 0};
        len  = 2;
        case (op)
            6'b100011: begin path = '{0, 1, 2, 3, 4};  len = 5; end
            6'b101011: begin path = '{0, 1, 2, 5, 0};  len = 4; end
            6'b001000: begin path = '{0, 1, 9, 10, 0}; len = 4; end
            6'b000100: begin path = '{0, 1, 8, 0, 0};  len = 3; end
            6'b000010: begin path = '{0, 1, 11, 0, 0}; len = 3; end
            6'b000000: if (modelLegal(fn)) begin path = '{0, 1, 6, 7, 0}; len = 4; end
            default: ;
        endcase
        return (k < len) ? path[k] : 0;
    endfunction

    function automatic int modelCpi(input logic [5:0] op, input logic [5:0] fn);
        int k = 1;
        while (stateAt(op, fn, k) != 0) k++;
        return k;
    endfunction

    function automatic logic [14:0] modelOut(input int s, input logic [5:0] fn,
                                             input logic z, input logic rst);
        logic ior, mw, irw, rdst, m2r, rw, srca, pce;
        logic [1:0] srcb, pcs;
        logic [2:0] alu;
        {ior, mw, irw, rdst, m2r, rw, srca, pce} = 8'b0;
        srcb = 2'b00;
        pcs  = 2'b00;
        alu  = 3'b010;
        if (rst) srcb = 2'b01;
        else begin
            case (s)
                0:     begin irw = 1'b1; pce = 1'b1; srcb = 2'b01; end
                1:     srcb = 2'b11;
                2, 9:  begin srca = 1'b1; srcb = 2'b10; end
                3:     ior = 1'b1;
                4:     begin rw = 1'b1; m2r = 1'b1; end
                5:     begin ior = 1'b1; mw = 1'b1; end
                6:     begin srca = 1'b1; alu = modelAlu(fn); end
                7:     begin rw = 1'b1; rdst = 1'b1; end
                10:    rw = 1'b1;
                8:     begin srca = 1'b1; alu = 3'b110; pcs = 2'b01; pce = z; end
                11:    begin pcs = 2'b10; pce = 1'b1; end
                default: ;
            endcase
        end
        return {ior, mw, irw, rdst, m2r, rw, srca, srcb, pcs, pce, alu};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs one instruction from FETCH until the DUT returns to FETCH, checking every cycle.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input string tag, output int cycles, output logic [2:0] alu2,
                                 output int rw, output int mw, output int pe);
        int k;
        int expS;
        opcode = op;
        funct  = fn;
        zero   = z;
        #1;
        k = 0; rw = 0; mw = 0; pe = 0; alu2 = 3'b010;
        do begin
            expS = stateAt(op, fn, k);
            checkOutput({tag, " state"}, 32'(state), 32'(expS));
            checkOutput({tag, " outputs"}, 32'(dutOut), 32'(modelOut(expS, fn, z, 1'b0)));
            if (regwrite) rw++;
            if (memwrite) mw++;
            if (pcen) pe++;
            if (k == 2) alu2 = alucontrol;
            @(posedge clk); #1;
            k++;
        end while (state != 4'd0 && k < 12);
        if (k >= 12) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s timeout: state %0d never returned to FETCH", tag, state);
        end
        cycles = k;
    endtask

    vec_t vecs[15];

    initial begin
        int cyc, rw, mw, pe;
        logic [2:0] a2;
        logic [5:0] opPool[7];
        logic [5:0] fnPool[7];
        logic [5:0] op, fn;

        vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 3'b010, 1, 0, 1};
        vecs[1]  = '{6'b000000, 6'b101010, 1'b0, 4, 3'b111, 1, 0, 1};
        vecs[2]  = '{6'b000000, 6'b000010, 1'b0, 4, 3'b101, 1, 0, 1};
        vecs[3]  = '{6'b000100, 6'b000000, 1'b1, 3, 3'b110, 0, 0, 2};
        vecs[4]  = '{6'b000100, 6'b000000, 1'b0, 3, 3'b110, 0, 0, 1};
        vecs[5]  = '{6'b101011, 6'b100000, 1'b0, 4, 3'b010, 0, 1, 1};
        vecs[6]  = '{6'b000010, 6'b000000, 1'b1, 3, 3'b010, 0, 0, 2};
        vecs[7]  = '{6'b001000, 6'b000000, 1'b0, 4, 3'b010, 1, 0, 1};
        vecs[8]  = '{6'b111111, 6'b100000, 1'b0, 2, 3'b010, 0, 0, 1};
        vecs[9]  = '{6'b000000, 6'b111111, 1'b0, 2, 3'b010, 0, 0, 1};
        vecs[10] = '{6'b000000, 6'b100000, 1'b0, 4, 3'b010, 1, 0, 1};
        vecs[11] = '{6'b000000, 6'b100010, 1'b0, 4, 3'b110, 1, 0, 1};
        vecs[12] = '{6'b000000, 6'b100100, 1'b0, 4, 3'b000, 1, 0, 1};
        vecs[13] = '{6'b000000, 6'b100101, 1'b1, 4, 3'b001, 1, 0, 1};
        vecs[14] = '{6'b000000, 6'b000000, 1'b0, 4, 3'b100, 1, 0, 1};

        reset  = 1'b1;
        opcode = 6'b0;
        funct  = 6'b0;
        zero   = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset outputs", 32'(dutOut), 32'(modelOut(0, 6'b0, 1'b0, 1'b1)));
        reset = 1'b0;
        #1;
        checkOutput("first fetch outputs", 32'(dutOut), 32'(modelOut(0, 6'b0, 1'b0, 1'b0)));

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].op, vecs[i].fn, vecs[i].z, $sformatf("vec%0d", i),
                          cyc, a2, rw, mw, pe);
            checkOutput($sformatf("vec%0d cycles", i), 32'(cyc), 32'(vecs[i].cycles));
            if (vecs[i].cycles > 2)
                checkOutput($sformatf("vec%0d exec alucontrol", i), 32'(a2), 32'(vecs[i].alu2));
            checkOutput($sformatf("vec%0d regwrite count", i), 32'(rw), 32'(vecs[i].rw));
            checkOutput($sformatf("vec%0d memwrite count", i), 32'(mw), 32'(vecs[i].mw));
            checkOutput($sformatf("vec%0d pcen count", i), 32'(pe), 32'(vecs[i].pe));
        end

        // Reset arriving mid-lw, held for two cycles, then released.
        opcode = 6'b100011;
        funct  = 6'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midreset pre state", 32'(state), 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("midreset comb outputs", 32'(dutOut), 32'(modelOut(0, 6'b0, 1'b0, 1'b1)));
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("midreset hold%0d state", c), 32'(state), 32'd0);
            checkOutput($sformatf("midreset hold%0d strobes", c),
                        32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
        end
        reset = 1'b0;
        #1;
        checkOutput("midreset release outputs", 32'(dutOut), 32'(modelOut(0, 6'b0, 1'b0, 1'b0)));
        applyStimulus(6'b001000, 6'b0, 1'b0, "post-reset addi", cyc, a2, rw, mw, pe);
        checkOutput("post-reset addi cycles", 32'(cyc), 32'd4);

        opPool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
        fnPool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010};
        for (int r = 0; r < 200; r++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            op  = (sel == 7) ? 6'($urandom) : opPool[sel];
            fn  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fnPool[$urandom_range(0, 6)];
            applyStimulus(op, fn, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r),
                          cyc, a2, rw, mw, pe);
            checkOutput($sformatf("rnd%0d cycles", r), 32'(cyc), 32'(modelCpi(op, fn)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
